cmos_pixel_capture: RTL and testbench

Parametrised camera-side pixel capture for the gesture pipeline, sitting directly behind the CMOS sensor DVP pins and ahead of the colour/skin-detection logic. It assembles BYTES_PER_PIX sensor bytes into one packed pixel, emits a one-cycle pixel strobe with X/Y coordinates, and discards a configurable number of start-up frames after I2C init. It also produces frame start/done pulses, and optionally crops to a runtime window.

---
 rtl/cmos_pixel_capture.sv | 165 ++++++++++++++++
 tb/tb_cmos_pixel_capture.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pixel_capture.sv
// DVP pixel capture: packs BYTES_PER_PIX sensor beats into a pixel, tracks X/Y and skips start-up frames.
// Optional runtime crop window is enabled with `define CMOS_CROP_EN.
module cmos_pixel_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int SKIP_FRAMES   = 10,
  parameter int CNT_W         = 12
) (
  input  logic                            CMOS_PCLK,
  input  logic                            iRST_N,
  input  logic                            Init_Done,
  input  logic [DATA_W-1:0]               CMOS_iDATA,
  input  logic                            CMOS_VSYNC,
  input  logic                            CMOS_HREF,
`ifdef CMOS_CROP_EN
  input  logic [CNT_W-1:0]                iX_START,
  input  logic [CNT_W-1:0]                iX_END,
  input  logic [CNT_W-1:0]                iY_START,
  input  logic [CNT_W-1:0]                iY_END,
`endif
  output logic [DATA_W*BYTES_PER_PIX-1:0] oPIX_DATA,
  output logic                            oPIX_VALID,
  output logic [CNT_W-1:0]                oX,
  output logic [CNT_W-1:0]                oY,
  output logic                            oFRAME_START,
  output logic                            oFRAME_DONE,
  output logic                            oFRAME_VALID,
  output logic                            oPARTIAL
);

  localparam int PIX_W = DATA_W * BYTES_PER_PIX;
  localparam logic [1:0] BC_LAST = 2'(BYTES_PER_PIX - 1);
  localparam logic [7:0] SKIP_LAST = 8'(SKIP_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, SKIP, ARM, ACTIVE} state_t;

  state_t            state;
  logic [7:0]        skip_cnt;
  logic              vs_d, hr_d;
  logic [1:0]        byte_cnt;
  logic [PIX_W-1:0]  hold;
  logic [CNT_W-1:0]  x_cnt, y_cnt;
  logic              line_pix;

  logic vs_fall, vs_rise, hr_fall, beat, active, in_win;
  logic [CNT_W-1:0] x_rep, y_rep;
  logic [PIX_W-1:0] pix_next;

  assign vs_fall  = vs_d & ~CMOS_VSYNC;
  assign vs_rise  = ~vs_d & CMOS_VSYNC;
  assign hr_fall  = hr_d & ~CMOS_HREF;
  assign beat     = ~CMOS_VSYNC & CMOS_HREF;
  assign active   = (state == ACTIVE) & Init_Done;
  // Oldest beat ends up in the MSBs after BYTES_PER_PIX shifts.
  assign pix_next = PIX_W'({hold, CMOS_iDATA});

`ifdef CMOS_CROP_EN
  logic [CNT_W-1:0] xs_r, xe_r, ys_r, ye_r;
  assign in_win = (x_cnt >= xs_r) && (x_cnt <= xe_r) && (y_cnt >= ys_r) && (y_cnt <= ye_r);
  assign x_rep  = x_cnt - xs_r;
  assign y_rep  = y_cnt - ys_r;

  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      xs_r <= '0;
      xe_r <= '0;
      ys_r <= '0;
      ye_r <= '0;
    end else if (vs_fall) begin
      xs_r <= iX_START;
      xe_r <= iX_END;
      ys_r <= iY_START;
      ye_r <= iY_END;
    end
  end
`else
  assign in_win = 1'b1;
  assign x_rep  = x_cnt;
  assign y_rep  = y_cnt;
`endif

  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= IDLE;
      skip_cnt     <= '0;
      oFRAME_START <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      oFRAME_VALID <= 1'b0;
    end else begin
      oFRAME_START <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      if (!Init_Done) begin
        state        <= IDLE;
        skip_cnt     <= '0;
        oFRAME_VALID <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            skip_cnt <= '0;
            state    <= (SKIP_FRAMES == 0) ? ARM : SKIP;
          end
          SKIP: if (vs_rise) begin
            skip_cnt <= skip_cnt + 8'd1;
            if (skip_cnt == SKIP_LAST) state <= ARM;
          end
          // ARM waits out the frame in progress so the first delivered frame is whole.
          ARM: if (vs_rise) begin
            state        <= ACTIVE;
            oFRAME_VALID <= 1'b1;
          end
          ACTIVE: begin
            oFRAME_START <= vs_fall;
            oFRAME_DONE  <= vs_rise;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vs_d       <= 1'b0;
      hr_d       <= 1'b0;
      byte_cnt   <= '0;
      hold       <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      line_pix   <= 1'b0;
      oPIX_DATA  <= '0;
      oPIX_VALID <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oPARTIAL   <= 1'b0;
    end else begin
      vs_d       <= CMOS_VSYNC;
      hr_d       <= CMOS_HREF;
      oPIX_VALID <= 1'b0;
      oPARTIAL   <= (hr_fall | vs_rise) & (byte_cnt != 2'd0) & active;
      if (beat) begin
        if (byte_cnt == BC_LAST) begin
          byte_cnt   <= '0;
          oPIX_DATA  <= pix_next;
          oPIX_VALID <= active & in_win;
          oX         <= x_rep;
          oY         <= y_rep;
          x_cnt      <= x_cnt + 1'b1;
          line_pix   <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          hold     <= pix_next;
        end
      end else begin
        byte_cnt <= '0;
      end
      if (hr_fall | vs_rise) begin
        x_cnt    <= '0;
        line_pix <= 1'b0;
      end
      if (hr_fall && line_pix) y_cnt <= y_cnt + 1'b1;
      if (vs_fall) y_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Scoreboard bench for cmos_pixel_capture: two instances (2 and 3 beats per pixel) share one sensor stream.
module tb_cmos_pixel_capture;

  logic        clk = 1'b0;
  logic        rst_n, init_done, vsync, href;
  logic [7:0]  data;
  logic [15:0] pix2;
  logic [23:0] pix3;
  logic        vld2, vld3, fs2, fs3, fd2, fd3, fv2, fv3, pt2, pt3;
  logic [11:0] x2, y2, x3, y3;
  logic [11:0] xs = 12'd0, xe = 12'hfff, ys = 12'd0, ye = 12'hfff;

  always #5 clk = ~clk;

  cmos_pixel_capture #(.DATA_W(8), .BYTES_PER_PIX(2), .SKIP_FRAMES(2), .CNT_W(12)) u2 (
    .CMOS_PCLK(clk), .iRST_N(rst_n), .Init_Done(init_done), .CMOS_iDATA(data),
    .CMOS_VSYNC(vsync), .CMOS_HREF(href),
`ifdef CMOS_CROP_EN
    .iX_START(xs), .iX_END(xe), .iY_START(ys), .iY_END(ye),
`endif
    .oPIX_DATA(pix2), .oPIX_VALID(vld2), .oX(x2), .oY(y2), .oFRAME_START(fs2),
    .oFRAME_DONE(fd2), .oFRAME_VALID(fv2), .oPARTIAL(pt2));

  cmos_pixel_capture #(.DATA_W(8), .BYTES_PER_PIX(3), .SKIP_FRAMES(2), .CNT_W(12)) u3 (
    .CMOS_PCLK(clk), .iRST_N(rst_n), .Init_Done(init_done), .CMOS_iDATA(data),
    .CMOS_VSYNC(vsync), .CMOS_HREF(href),
`ifdef CMOS_CROP_EN
    .iX_START(xs), .iX_END(xe), .iY_START(ys), .iY_END(ye),
`endif
    .oPIX_DATA(pix3), .oPIX_VALID(vld3), .oX(x3), .oY(y3), .oFRAME_START(fs3),
    .oFRAME_DONE(fd3), .oFRAME_VALID(fv3), .oPARTIAL(pt3));

  typedef struct {
    logic [31:0] d;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  logic [7:0] pat [0:15][0:15];
  int tests = 0, fails = 0;
  int n_start = 0, n_done = 0, n_part = 0, npix2 = 0, npix3 = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int seed);
    for (int l = 0; l < 16; l++)
      for (int i = 0; i < 16; i++)
        pat[l][i] = 8'(seed + l * 37 + i * 11);
  endtask

  task automatic push(input int bpp, input logic [31:0] d, input int x, input int y);
    exp_t e;
    if (x < int'(xs) || x > int'(xe) || y < int'(ys) || y > int'(ye)) return;
    e.d = d;
    e.x = 12'(x - int'(xs));
    e.y = 12'(y - int'(ys));
    if (bpp == 2) q2.push_back(e);
    else q3.push_back(e);
  endtask

  // One frame of lines x nb bytes; cut raises VSYNC while the last line's HREF is still high.
  task automatic frame(input int lines, input int nb, input bit act, input bit cut);
    vsync = 1'b0;
    repeat (3) step();
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < nb; i++) begin
        href = 1'b1;
        data = pat[l][i];
        if (act && (i % 2) == 1) push(2, {16'd0, pat[l][i-1], pat[l][i]}, i / 2, l);
        if (act && (i % 3) == 2) push(3, {8'd0, pat[l][i-2], pat[l][i-1], pat[l][i]}, i / 3, l);
        step();
      end
      if (cut && l == lines - 1) begin
        vsync = 1'b1;
        step();
      end
      href = 1'b0;
      repeat (3) step();
    end
    vsync = 1'b1;
    repeat (4) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vld2) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL pix2_unexpected: got data=%h x=%0d y=%0d, expected no strobe", pix2, x2, y2);
      end else begin
        e = q2.pop_front();
        npix2++;
        if ({16'd0, pix2} !== e.d || x2 !== e.x || y2 !== e.y) begin
          fails++;
          $display("FAIL pix2: got data=%h x=%0d y=%0d, expected data=%h x=%0d y=%0d",
                   pix2, x2, y2, e.d[15:0], e.x, e.y);
        end
      end
    end
    if (vld3) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL pix3_unexpected: got data=%h x=%0d y=%0d, expected no strobe", pix3, x3, y3);
      end else begin
        e = q3.pop_front();
        npix3++;
        if ({8'd0, pix3} !== e.d || x3 !== e.x || y3 !== e.y) begin
          fails++;
          $display("FAIL pix3: got data=%h x=%0d y=%0d, expected data=%h x=%0d y=%0d",
                   pix3, x3, y3, e.d[23:0], e.x, e.y);
        end
      end
    end
    if (fs2) n_start++;
    if (fd2) n_done++;
    if (pt2) n_part++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    tests++;
    if (pix2 !== 16'd0 || vld2 !== 1'b0 || x2 !== 12'd0 || y2 !== 12'd0 || fs2 !== 1'b0 ||
        fd2 !== 1'b0 || fv2 !== 1'b0 || pt2 !== 1'b0 || pix3 !== 24'd0 || vld3 !== 1'b0) begin
      fails++;
      $display("FAIL %s: got pix=%h vld=%b x=%0d y=%0d fs=%b fd=%b fv=%b pt=%b pix3=%h, expected all zero",
               tag, pix2, vld2, x2, y2, fs2, fd2, fv2, pt2, pix3);
    end
  endtask

  task automatic queues_empty(input string tag);
    check({tag, "_q2_empty"}, q2.size(), 0);
    check({tag, "_q3_empty"}, q3.size(), 0);
  endtask

  task automatic run_skip_sequence();
    for (int f = 0; f < 3; f++) frame(4, 8, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_done = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'hff;
    repeat (3) step();
    check_zero_outputs("reset_hold");
    rst_n = 1'b1;
    repeat (3) step();
    check_zero_outputs("reset_release");
  endtask

  task automatic test_skip();
    int p0, s0, d0;
    fill(3);
    init_done = 1'b1;
    step();
    p0 = npix2; s0 = n_start; d0 = n_done;
    frame(4, 8, 1'b0, 1'b0);
    frame(4, 8, 1'b0, 1'b0);
    check("skip_valid_before_arm_end", fv2, 0);
    frame(4, 8, 1'b0, 1'b0);
    check("skip_no_start", n_start - s0, 0);
    check("skip_no_done", n_done - d0, 0);
    check("skip_valid_active", fv2, 1);
    frame(4, 8, 1'b1, 1'b0);
    check("skip_pix_count", npix2 - p0, 16);
    check("skip_start_count", n_start - s0, 1);
    check("skip_done_count", n_done - d0, 1);
    check("skip_data_hold", pix2, {pat[3][6], pat[3][7]});
    queues_empty("skip");
  endtask

  task automatic test_pack();
    fill(9);
    pat[0][0] = 8'hA1; pat[0][1] = 8'hB2; pat[0][2] = 8'hC3;
    pat[0][6] = 8'h12; pat[0][7] = 8'h34;
    frame(2, 8, 1'b1, 1'b0);
    queues_empty("pack");
  endtask

  task automatic test_partial();
    int k0, p0;
    fill(21);
    k0 = n_part; p0 = npix2;
    frame(1, 7, 1'b1, 1'b0);
    check("partial_one_pulse", n_part - k0, 1);
    check("partial_three_pix", npix2 - p0, 3);
    k0 = n_part;
    frame(2, 7, 1'b1, 1'b0);
    check("partial_two_lines", n_part - k0, 2);
    queues_empty("partial");
  endtask

  task automatic test_vsync_cut();
    int k0, d0;
    fill(44);
    k0 = n_part; d0 = n_done;
    frame(1, 5, 1'b1, 1'b1);
    check("cut_partial", n_part - k0, 1);
    check("cut_done", n_done - d0, 1);
    queues_empty("cut");
  endtask

  task automatic test_init_drop();
    int d0, p0;
    d0 = n_done; p0 = npix2;
    vsync = 1'b0;
    repeat (3) step();
    href = 1'b1; data = 8'h10;
    step();
    data = 8'h20; init_done = 1'b0;
    step();
    @(negedge clk);
    check("drop_frame_valid", fv2, 0);
    for (int i = 0; i < 6; i++) begin
      data = 8'(i);
      step();
    end
    href = 1'b0;
    repeat (2) step();
    vsync = 1'b1;
    repeat (4) step();
    check("drop_no_done", n_done - d0, 0);
    check("drop_no_pix", npix2 - p0, 0);
    init_done = 1'b1;
    step();
    fill(57);
    run_skip_sequence();
    check("drop_reskip_pix", npix2 - p0, 0);
    d0 = n_done;
    frame(4, 8, 1'b1, 1'b0);
    check("drop_reactive_done", n_done - d0, 1);
    check("drop_reactive_pix", npix2 - p0, 16);
    queues_empty("drop");
  endtask

  task automatic test_reset_mid();
    int p0;
    vsync = 1'b0;
    repeat (3) step();
    push(2, 32'h5566, 0, 0);
    push(3, 32'h556677, 0, 0);
    href = 1'b1;
    data = 8'h55; step();
    data = 8'h66; step();
    data = 8'h77; step();
    data = 8'h88; step();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset_async");
    queues_empty("midreset");
    href = 1'b0;
    step();
    vsync = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    p0 = npix2;
    fill(77);
    run_skip_sequence();
    check("midreset_reskip_pix", npix2 - p0, 0);
    frame(4, 8, 1'b1, 1'b0);
    check("midreset_active_pix", npix2 - p0, 16);
    queues_empty("midreset_final");
  endtask

`ifdef CMOS_CROP_EN
  task automatic test_crop();
    int p0, p3;
    xs = 12'd1; xe = 12'd2; ys = 12'd1; ye = 12'd1;
    p0 = npix2; p3 = npix3;
    fill(88);
    frame(4, 8, 1'b1, 1'b0);
    check("crop_pix2_count", npix2 - p0, 2);
    check("crop_pix3_count", npix3 - p3, 1);
    queues_empty("crop");
    xs = 12'd0; xe = 12'hfff; ys = 12'd0; ye = 12'hfff;
  endtask
`endif

  initial begin
    test_reset();
    test_skip();
    test_pack();
    test_partial();
    test_vsync_cut();
`ifdef CMOS_CROP_EN
    test_crop();
`endif
    test_init_drop();
    test_reset_mid();
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
